// File: rtl/i2c_sram_embedded.sv
// I2C leaf slave with a 256 x 16-bit memory. A transaction carries a device
// address with an R/W bit, an 8-bit word address, and then one 16-bit word,
// high byte first. START and STOP are caught by two small flops clocked on
// SDA edges. Everything else runs on SCL: the FSM samples on the rising edge,
// and the SDA driver updates on the falling edge.
module i2c_sram_embedded (
  input  logic        scl,
  input  logic        reset,
  inout  wire         sda,
  input  logic [6:0]  my_addr,
  output logic [7:0]  curr_data,
  output logic [6:0]  rcvd_device_address,
  output logic        rcvd_mode,
  output logic [32:0] state
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_DEV_ADDR   = 4'd1,
    S_MODE       = 4'd2,
    S_ADDR_ACK   = 4'd3,
    S_MEM_ADDR   = 4'd4,
    S_MEM_ACK    = 4'd5,
    S_WR_HI      = 4'd6,
    S_WR_HI_ACK  = 4'd7,
    S_WR_LO      = 4'd8,
    S_WR_LO_ACK  = 4'd9,
    S_RD_HI      = 4'd10,
    S_RD_HI_MACK = 4'd11,
    S_RD_LO      = 4'd12,
    S_RD_LO_MACK = 4'd13,
    S_WAIT_STOP  = 4'd14
  } state_e;

  state_e      state_q, state_d, cur_state;
  logic [2:0]  cnt_q, cnt_d, cur_cnt;
  logic [7:0]  data_q, data_d;
  logic [6:0]  dev_q, dev_d;
  logic        mode_q, mode_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] shreg_q, shreg_d;
  logic        oe_q, oe_d;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] rd_word;
  logic [15:0] mem_q [256];
  logic [7:0]  rx_byte;

  // Bus-condition bookkeeping. The SDA-edge flops toggle once per event.
  // The SCL domain acknowledges an event by copying the toggle value on its
  // next rising edge. The stop snapshot records which START the last STOP
  // followed, so that a START issued after a STOP takes precedence.
  logic start_tog_q, stop_tog_q, stop_snap_q;
  logic start_ack_q, stop_ack_q;
  logic start_pend, stop_pend, stop_last, bus_start, bus_stop;

  // START: SDA falls while SCL is high.
  always_ff @(negedge sda or posedge reset) begin
    if (reset) begin
      start_tog_q <= 1'b0;
    end else if (scl) begin
      start_tog_q <= ~start_tog_q;
    end
  end

  // STOP: SDA rises while SCL is high; also remember which START preceded it.
  always_ff @(posedge sda or posedge reset) begin
    if (reset) begin
      stop_tog_q  <= 1'b0;
      stop_snap_q <= 1'b0;
    end else if (scl) begin
      stop_tog_q  <= ~stop_tog_q;
      stop_snap_q <= start_tog_q;
    end
  end

  assign start_pend = start_tog_q ^ start_ack_q;
  assign stop_pend  = stop_tog_q ^ stop_ack_q;
  assign stop_last  = stop_pend & (stop_snap_q == start_tog_q);
  assign bus_start  = start_pend & ~stop_last;
  assign bus_stop   = stop_pend & ~bus_start;

  // A pending START or STOP overrides the registered state immediately,
  // without waiting for the next SCL edge.
  assign cur_state = bus_start ? S_DEV_ADDR : (bus_stop ? S_IDLE : state_q);
  assign cur_cnt   = bus_start ? 3'd0 : cnt_q;

  assign rx_byte   = {data_q[6:0], sda};
  assign rd_word   = mem_q[addr_q];
  assign mem_wdata = {hi_q, rx_byte};

  // Next-state and datapath decode for the rising SCL edge.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = cur_state;
    cnt_d   = cur_cnt;
    data_d  = data_q;
    dev_d   = dev_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    shreg_d = shreg_q;
    mem_we  = 1'b0;
    unique case (cur_state)
      S_IDLE: ;
      S_DEV_ADDR: begin
        data_d = rx_byte;
        cnt_d  = cur_cnt + 3'd1;
        if (cur_cnt == 3'd6) begin
          state_d = S_MODE;
          cnt_d   = 3'd0;
        end
      end
      S_MODE: begin
        data_d  = rx_byte;
        dev_d   = data_q[6:0];
        mode_d  = sda;
        state_d = S_ADDR_ACK;
      end
      S_ADDR_ACK: state_d = (dev_q == my_addr) ? S_MEM_ADDR : S_WAIT_STOP;
      S_MEM_ADDR: begin
        data_d = rx_byte;
        cnt_d  = cur_cnt + 3'd1;
        if (cur_cnt == 3'd7) begin
          addr_d  = rx_byte;
          state_d = S_MEM_ACK;
        end
      end
      S_MEM_ACK: begin
        if (mode_q) begin
          state_d = S_RD_HI;
          shreg_d = rd_word;
          data_d  = rd_word[15:8];
        end else begin
          state_d = S_WR_HI;
        end
      end
      S_WR_HI: begin
        data_d = rx_byte;
        cnt_d  = cur_cnt + 3'd1;
        if (cur_cnt == 3'd7) begin
          hi_d    = rx_byte;
          state_d = S_WR_HI_ACK;
        end
      end
      S_WR_HI_ACK: state_d = S_WR_LO;
      S_WR_LO: begin
        data_d = rx_byte;
        cnt_d  = cur_cnt + 3'd1;
        if (cur_cnt == 3'd7) begin
          mem_we  = 1'b1;
          state_d = S_WR_LO_ACK;
        end
      end
      S_WR_LO_ACK: state_d = S_WAIT_STOP;
      S_RD_HI: begin
        shreg_d = {shreg_q[14:0], 1'b0};
        cnt_d   = cur_cnt + 3'd1;
        if (cur_cnt == 3'd7) state_d = S_RD_HI_MACK;
      end
      S_RD_HI_MACK: begin
        if (!sda) begin
          state_d = S_RD_LO;
          data_d  = shreg_q[15:8];
        end else begin
          state_d = S_WAIT_STOP;
        end
      end
      S_RD_LO: begin
        shreg_d = {shreg_q[14:0], 1'b0};
        cnt_d   = cur_cnt + 3'd1;
        if (cur_cnt == 3'd7) state_d = S_RD_LO_MACK;
      end
      S_RD_LO_MACK: state_d = S_WAIT_STOP;
      S_WAIT_STOP: ;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and datapath registers, sampled on the rising SCL edge.
  always_ff @(posedge scl or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      data_q      <= 8'd0;
      dev_q       <= 7'd0;
      mode_q      <= 1'b0;
      addr_q      <= 8'd0;
      hi_q        <= 8'd0;
      shreg_q     <= 16'd0;
      start_ack_q <= 1'b0;
      stop_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      dev_q       <= dev_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      hi_q        <= hi_d;
      shreg_q     <= shreg_d;
      start_ack_q <= start_tog_q;
      stop_ack_q  <= stop_tog_q;
    end
  end

  // Word storage; the word is written as the last low-byte bit is sampled.
  always_ff @(posedge scl or posedge reset) begin
    // NOTE: the memory is reset on purpose, because contents must read back as zero after reset.
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= 16'd0;
    end else if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  // SDA drive decision, computed from the state just entered.
  always_comb begin
    oe_d = 1'b0;
    unique case (cur_state)
      S_ADDR_ACK:                          oe_d = (dev_q == my_addr);
      S_MEM_ACK, S_WR_HI_ACK, S_WR_LO_ACK: oe_d = 1'b1;
      S_RD_HI, S_RD_LO:                    oe_d = ~shreg_q[15];
      default:                             oe_d = 1'b0;
    endcase
  end

  // SDA changes only on the falling SCL edge.
  always_ff @(negedge scl or posedge reset) begin
    if (reset) begin
      oe_q <= 1'b0;
    end else begin
      oe_q <= oe_d;
    end
  end

  // Open-drain output: pull low or release. A STOP releases the line at once.
  assign sda = (oe_q && (cur_state != S_IDLE)) ? 1'b0 : 1'bz;

  assign curr_data           = data_q;
  assign rcvd_device_address = dev_q;
  assign rcvd_mode           = mode_q;
  assign state               = {29'd0, cur_state};

endmodule

// File: tb/tb_i2c_sram_embedded.sv
// Bench for i2c_sram_embedded: a bit-banged I2C master drives directed
// transactions and pushes expected results into a queue. Observations taken
// from the bus and the debug ports go into a second queue, and a monitor
// process pairs the two queues up and compares them.
module tb_i2c_sram_embedded;

  logic        scl = 1'b1;
  logic        reset = 1'b1;
  logic        md_low = 1'b0;
  logic [6:0]  my_addr = 7'h3C;
  wire         sda;
  logic [7:0]  curr_data;
  logic [6:0]  rcvd_device_address;
  logic        rcvd_mode;
  logic [32:0] state;

  assign sda = md_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_sram_embedded dut (
    .scl                 (scl),
    .reset               (reset),
    .sda                 (sda),
    .my_addr             (my_addr),
    .curr_data           (curr_data),
    .rcvd_device_address (rcvd_device_address),
    .rcvd_mode           (rcvd_mode),
    .state               (state)
  );

  typedef struct {
    string       name;
    logic [32:0] val;
  } item_t;

  item_t exp_q[$];
  item_t act_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_val(input string name, input logic [32:0] v);
    item_t it;
    it.name = name;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic observe(input string name, input logic [32:0] v);
    item_t it;
    it.name = name;
    it.val  = v;
    act_q.push_back(it);
  endtask

  // Monitor: pair each observation with the oldest outstanding expectation.
  initial begin
    item_t a;
    item_t e;
    forever begin
      #1;
      while (act_q.size() != 0) begin
        a = act_q.pop_front();
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL %s: unexpected observation 0x%0h", a.name, a.val);
        end else begin
          e = exp_q.pop_front();
          check(e.name, a.val, e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  // One SCL pulse: present a bit while SCL is low, sample SDA mid-high.
  task automatic clk_bit(input logic b, output logic s);
    md_low = ~b;
    #5;
    scl = 1'b1;
    #2;
    s = sda;
    #3;
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(~mack, s);
  endtask

  task automatic start_cond;
    md_low = 1'b0;
    #5;
    scl = 1'b1;
    #5;
    md_low = 1'b1;
    #5;
    scl = 1'b0;
  endtask

  task automatic stop_cond;
    md_low = 1'b1;
    #5;
    scl = 1'b1;
    #5;
    md_low = 1'b0;
    #5;
  endtask

  task automatic wr_body(input logic [6:0] dev, input logic [7:0] a, input logic [15:0] w);
    logic ack;
    expect_val("wr_hdr_ack", 1);
    send_byte({dev, 1'b0}, ack);
    observe("wr_hdr_ack", ack);
    expect_val("wr_addr_ack", 1);
    send_byte(a, ack);
    observe("wr_addr_ack", ack);
    expect_val("wr_hi_ack", 1);
    send_byte(w[15:8], ack);
    observe("wr_hi_ack", ack);
    expect_val("wr_lo_ack", 1);
    send_byte(w[7:0], ack);
    observe("wr_lo_ack", ack);
    expect_val("wr_state_wait", 14);
    observe("wr_state_wait", state);
    stop_cond;
    expect_val("wr_state_idle", 0);
    observe("wr_state_idle", state);
  endtask

  task automatic wr_txn(input logic [6:0] dev, input logic [7:0] a, input logic [15:0] w);
    start_cond;
    wr_body(dev, a, w);
  endtask

  task automatic rd_txn(input logic [6:0] dev, input logic [7:0] a, input logic [15:0] w);
    logic       ack;
    logic [7:0] b;
    start_cond;
    expect_val("rd_hdr_ack", 1);
    send_byte({dev, 1'b1}, ack);
    observe("rd_hdr_ack", ack);
    expect_val("rd_addr_ack", 1);
    send_byte(a, ack);
    observe("rd_addr_ack", ack);
    expect_val("rd_hi", {25'd0, w[15:8]});
    recv_byte(1'b1, b);
    observe("rd_hi", b);
    expect_val("rd_lo", {25'd0, w[7:0]});
    recv_byte(1'b0, b);
    observe("rd_lo", b);
    expect_val("rd_curr_data", {25'd0, w[7:0]});
    observe("rd_curr_data", curr_data);
    expect_val("rd_state_wait", 14);
    observe("rd_state_wait", state);
    stop_cond;
    expect_val("rd_state_idle", 0);
    observe("rd_state_idle", state);
  endtask

  initial begin
    logic       ack;
    logic       s;
    item_t      e;

    // Reset state.
    #10;
    expect_val("rst_state", 0);
    observe("rst_state", state);
    expect_val("rst_curr_data", 0);
    observe("rst_curr_data", curr_data);
    expect_val("rst_dev", 0);
    observe("rst_dev", rcvd_device_address);
    expect_val("rst_mode", 0);
    observe("rst_mode", rcvd_mode);
    expect_val("rst_sda", 1);
    observe("rst_sda", sda);
    reset = 1'b0;
    #10;

    // Read from fresh memory.
    rd_txn(7'h3C, 8'h7C, 16'h0000);
    expect_val("hdr_dev", 7'h3C);
    observe("hdr_dev", rcvd_device_address);
    expect_val("hdr_mode", 1);
    observe("hdr_mode", rcvd_mode);

    // Write then read back, two patterns.
    wr_txn(7'h3C, 8'h7C, 16'h5093);
    rd_txn(7'h3C, 8'h7C, 16'h5093);
    wr_txn(7'h3C, 8'h7C, 16'h04D2);
    rd_txn(7'h3C, 8'h7C, 16'h04D2);

    // Wrong device address: no ACK, parked in WAIT_STOP, memory untouched.
    start_cond;
    expect_val("nm_hdr_ack", 0);
    send_byte({7'h3D, 1'b0}, ack);
    observe("nm_hdr_ack", ack);
    expect_val("nm_state", 14);
    observe("nm_state", state);
    expect_val("nm_addr_ack", 0);
    send_byte(8'h7C, ack);
    observe("nm_addr_ack", ack);
    expect_val("nm_state2", 14);
    observe("nm_state2", state);
    stop_cond;
    expect_val("nm_state_idle", 0);
    observe("nm_state_idle", state);
    expect_val("nm_dev", 7'h3D);
    observe("nm_dev", rcvd_device_address);
    rd_txn(7'h3C, 8'h7C, 16'h04D2);

    // Reset asserted in the middle of the low data byte.
    start_cond;
    send_byte({7'h3C, 1'b0}, ack);
    send_byte(8'h7C, ack);
    send_byte(8'hAB, ack);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    expect_val("mid_wr_lo_state", 8);
    observe("mid_wr_lo_state", state);
    md_low = 1'b0;
    reset  = 1'b1;
    #2;
    expect_val("rst_mid_state", 0);
    observe("rst_mid_state", state);
    expect_val("rst_mid_sda", 1);
    observe("rst_mid_sda", sda);
    #3;
    reset = 1'b0;
    #5;
    stop_cond;
    rd_txn(7'h3C, 8'h7C, 16'h0000);

    // Repeated START during MEM_ADDR, then a complete new write.
    start_cond;
    expect_val("rs_hdr_ack", 1);
    send_byte({7'h3C, 1'b0}, ack);
    observe("rs_hdr_ack", ack);
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    expect_val("rs_state_mem_addr", 4);
    observe("rs_state_mem_addr", state);
    start_cond;
    expect_val("rs_state_dev_addr", 1);
    observe("rs_state_dev_addr", state);
    wr_body(7'h3C, 8'h05, 16'h1357);
    rd_txn(7'h3C, 8'h05, 16'h1357);

    // Drain the monitor, then account for anything never observed.
    for (int k = 0; k < 100 && act_q.size() != 0; k++) #1;
    #2;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s: never observed, expected 0x%0h", e.name, e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
